// File: rtl/generate_graphic.sv
// Pixel colour generator for the 640x480 VGA path: draws a framed 3x3 board with per-cell markers.
// Optional macro TEST_PATTERN_EN adds a test_mode input that selects 8 vertical colour bars.
module generate_graphic #(
    parameter int unsigned H_START  = 144,
    parameter int unsigned V_START  = 35,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned LINE_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [17:0] cell_state,
`ifdef TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic        vga_sync,
    output logic        vga_blank,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b
);

    localparam int unsigned BOARD_W  = V_ACTIVE;
    localparam int unsigned BOARD_X0 = (H_ACTIVE - V_ACTIVE) / 2;
    localparam int unsigned CELL_W   = BOARD_W / 3;
    localparam int unsigned MARK_LO  = CELL_W / 4;
    localparam int unsigned MARK_HI  = CELL_W - MARK_LO;
    localparam int unsigned HALF_LW  = LINE_W / 2;

    localparam logic [23:0] C_BLACK = 24'h000000;
    localparam logic [23:0] C_GREY  = 24'h202020;
    localparam logic [23:0] C_WHITE = 24'hFFFFFF;
    localparam logic [23:0] C_RED   = 24'hFF0000;
    localparam logic [23:0] C_BLUE  = 24'h0000FF;
    localparam logic [23:0] C_GREEN = 24'h00FF00;

    // Board-local coordinate lies on the outer frame or on one of the two inner grid lines.
    function automatic logic on_line(input logic [9:0] v);
        return (v < 10'(LINE_W)) || (v >= 10'(BOARD_W - LINE_W))
            || ((v >= 10'(CELL_W - HALF_LW))     && (v < 10'(CELL_W + HALF_LW)))
            || ((v >= 10'(2 * CELL_W - HALF_LW)) && (v < 10'(2 * CELL_W + HALF_LW)));
    endfunction

    logic        active;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [9:0]  bx;
    logic [1:0]  col;
    logic [1:0]  row;
    logic [9:0]  cx;
    logic [9:0]  cy;
    logic [3:0]  cell_idx;
    logic [1:0]  code;
    logic        in_mark;
`ifdef TEST_PATTERN_EN
    logic [2:0]  bar;
`endif

    logic [23:0] rgb_d,   rgb_q;
    logic        blank_d, blank_q;
    logic        sync_d,  sync_q;

    // Next pixel colour from position and cell states.
    always_comb begin
        rgb_d   = C_BLACK;
        blank_d = 1'b0;
        sync_d  = 1'b0;

        active = (x >= 10'(H_START)) && (x < 10'(H_START + H_ACTIVE))
              && (y >= 10'(V_START)) && (y < 10'(V_START + V_ACTIVE));
        px = x - 10'(H_START);
        py = y - 10'(V_START);
        bx = px - 10'(BOARD_X0);

        // Cell split with comparators: no divider needed for three cells.
        if (bx < 10'(CELL_W)) begin
            col = 2'd0;
            cx  = bx;
        end else if (bx < 10'(2 * CELL_W)) begin
            col = 2'd1;
            cx  = bx - 10'(CELL_W);
        end else begin
            col = 2'd2;
            cx  = bx - 10'(2 * CELL_W);
        end
        if (py < 10'(CELL_W)) begin
            row = 2'd0;
            cy  = py;
        end else if (py < 10'(2 * CELL_W)) begin
            row = 2'd1;
            cy  = py - 10'(CELL_W);
        end else begin
            row = 2'd2;
            cy  = py - 10'(2 * CELL_W);
        end

        cell_idx = 4'(row) * 4'd3 + 4'(col);
        code     = cell_state[{cell_idx, 1'b0} +: 2];
        in_mark  = (cx >= 10'(MARK_LO)) && (cx < 10'(MARK_HI))
                && (cy >= 10'(MARK_LO)) && (cy < 10'(MARK_HI));

`ifdef TEST_PATTERN_EN
        bar = 3'd0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (px >= 10'(k * (H_ACTIVE / 8))) bar = 3'(k);
        end
`endif

        if (active) begin
            blank_d = 1'b1;
            if ((px < 10'(BOARD_X0)) || (px >= 10'(BOARD_X0 + BOARD_W))) begin
                rgb_d = C_GREY;
            end else if (on_line(bx) || on_line(py)) begin
                rgb_d = C_BLACK;
            end else if (in_mark && (code != 2'b00)) begin
                case (code)
                    2'b01:   rgb_d = C_RED;
                    2'b10:   rgb_d = C_BLUE;
                    default: rgb_d = C_GREEN;
                endcase
            end else begin
                rgb_d = C_WHITE;
            end
`ifdef TEST_PATTERN_EN
            // Bar index bits map directly onto inverted G (bit2), R (bit1), B (bit0).
            if (test_mode) rgb_d = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q   <= C_BLACK;
            blank_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            blank_q <= blank_d;
            sync_q  <= sync_d;
        end
    end

    assign vga_sync  = sync_q;
    assign vga_blank = blank_q;
    assign r         = rgb_q[23:16];
    assign g         = rgb_q[15:8];
    assign b         = rgb_q[7:0];

endmodule

// File: tb/tb_generate_graphic.sv
// Bench for generate_graphic: directed literal checks plus random pixels against a behavioural model.
module tb_generate_graphic;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [17:0] cs;
    bit          tm = 1'b0;
    logic        vga_sync;
    logic        vga_blank;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;

    int total = 0;
    int bad   = 0;

    logic [25:0] exp_q;

    generate_graphic dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (x),
        .y          (y),
        .cell_state (cs),
`ifdef TEST_PATTERN_EN
        .test_mode  (tm),
`endif
        .vga_sync   (vga_sync),
        .vga_blank  (vga_blank),
        .r          (r),
        .g          (g),
        .b          (b)
    );

    always #5 clk = ~clk;

    // Expected {sync, blank, rgb} computed directly from the drawing rules.
    function automatic logic [25:0] model(input int xx, input int yy, input logic [17:0] c, input bit t);
        int px, py, bx, by, col, row, cx, cy, code, bar;
        logic [23:0] rgb;
        if (!(xx >= 144 && xx < 784 && yy >= 35 && yy < 515)) return 26'h0;
        px = xx - 144;
        py = yy - 35;
        if (t) begin
            bar = px / 80;
            case (bar)
                0: rgb = 24'hFFFFFF;
                1: rgb = 24'hFFFF00;
                2: rgb = 24'h00FFFF;
                3: rgb = 24'h00FF00;
                4: rgb = 24'hFF00FF;
                5: rgb = 24'hFF0000;
                6: rgb = 24'h0000FF;
                default: rgb = 24'h000000;
            endcase
            return {2'b01, rgb};
        end
        if (px < 80 || px >= 560) return {2'b01, 24'h202020};
        bx = px - 80;
        by = py;
        if (bx < 4 || bx > 475 || by < 4 || by > 475) return {2'b01, 24'h000000};
        if ((bx >= 158 && bx <= 161) || (bx >= 318 && bx <= 321) ||
            (by >= 158 && by <= 161) || (by >= 318 && by <= 321)) return {2'b01, 24'h000000};
        col  = bx / 160;
        row  = by / 160;
        cx   = bx % 160;
        cy   = by % 160;
        code = int'((c >> (2 * (row * 3 + col))) & 18'h3);
        if (cx >= 40 && cx < 120 && cy >= 40 && cy < 120 && code != 0) begin
            case (code)
                1: rgb = 24'hFF0000;
                2: rgb = 24'h0000FF;
                default: rgb = 24'h00FF00;
            endcase
            return {2'b01, rgb};
        end
        return {2'b01, 24'hFFFFFF};
    endfunction

    function automatic logic [25:0] dut_out();
        return {vga_sync, vga_blank, r, g, b};
    endfunction

    task automatic check(input string name, input logic [25:0] got, input logic [25:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got sync/blank/rgb=%0b/%0b/%06h want %0b/%0b/%06h",
                     name, got[25], got[24], got[23:0], want[25], want[24], want[23:0]);
        end
    endtask

    // One-cycle-latency model register.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q <= 26'h0;
        else        exp_q <= model(int'(x), int'(y), cs, tm);
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("model", dut_out(), exp_q);
    end

    task automatic dir(input int xi, input int yi, input logic [17:0] ci, input bit ti,
                       input logic [25:0] want, input string name);
        @(posedge clk);
        #1;
        x  = 10'(xi);
        y  = 10'(yi);
        cs = ci;
        tm = ti;
        @(posedge clk);
        #1;
        check(name, dut_out(), want);
    endtask

    initial begin
        rst_n = 1'b0;
        x  = 10'($urandom_range(0, 799));
        y  = 10'($urandom_range(0, 524));
        cs = 18'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", dut_out(), 26'h0);
        x  = 10'd0;
        y  = 10'd0;
        cs = 18'h0;
        rst_n = 1'b1;

        dir(0, 0, 18'h0, 1'b0, 26'h0, "origin_blank");
        for (int i = 145; i <= 153; i++) dir(i, 35, 18'h0, 1'b0, {2'b01, 24'h202020}, "left_margin_grey");
        dir(143, 35, 18'h0, 1'b0, 26'h0, "x_before_active");
        dir(144, 34, 18'h0, 1'b0, 26'h0, "y_before_active");
        dir(224, 35, 18'h0, 1'b0, {2'b01, 24'h000000}, "frame_bx0");
        dir(304, 135, 18'h0, 1'b0, {2'b01, 24'hFFFFFF}, "bg_white");
        dir(304, 95, 18'h1, 1'b0, {2'b01, 24'hFF0000}, "cell0_red");
        dir(304, 95, 18'h2, 1'b0, {2'b01, 24'h0000FF}, "cell0_blue");
        dir(304, 95, 18'h3, 1'b0, {2'b01, 24'h00FF00}, "cell0_green");
        dir(624, 435, 18'h20000, 1'b0, {2'b01, 24'h0000FF}, "cell8_blue");
        dir(384, 435, 18'h20000, 1'b0, {2'b01, 24'h000000}, "grid_bx160");
        dir(703, 200, 18'h0, 1'b0, {2'b01, 24'h000000}, "frame_bx479");
        dir(704, 200, 18'h0, 1'b0, {2'b01, 24'h202020}, "right_margin_grey");
        dir(784, 100, 18'h0, 1'b0, 26'h0, "x_after_active");
        dir(300, 515, 18'h0, 1'b0, 26'h0, "y_after_active");
        dir(900, 600, 18'h3FFFF, 1'b0, 26'h0, "out_of_range");
`ifdef TEST_PATTERN_EN
        dir(544, 100, 18'h0, 1'b1, {2'b01, 24'hFF0000}, "bar5_red");
        dir(144, 100, 18'h0, 1'b1, {2'b01, 24'hFFFFFF}, "bar0_white");
        dir(544, 20, 18'h0, 1'b1, 26'h0, "bar_blanked");
`endif

        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 1) == 0) begin
                x = 10'($urandom_range(224, 703));
                y = 10'($urandom_range(35, 514));
            end else begin
                x = 10'($urandom_range(0, 1023));
                y = 10'($urandom_range(0, 1023));
            end
            cs = 18'($urandom);
`ifdef TEST_PATTERN_EN
            tm = ($urandom_range(0, 3) == 0);
`endif
            if (n == 2000) begin
                #3;
                rst_n = 1'b0;
                #1;
                check("async_reset", dut_out(), 26'h0);
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        end

        @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
